// File: rtl/v_alu_pkg.sv
// v_alu_pkg: opcodes and width helpers shared by the pipelined vector ALU
package v_alu_pkg;
    localparam int OP_NOP     = 0;
    localparam int OP_VADD    = 1;
    localparam int OP_VMUL    = 2;
    localparam int OP_VSUB    = 3;
    localparam int OP_VREDSUM = 4;

    function automatic int num_lanes(input int vreg_dw, input int sew);
        return vreg_dw / sew;
    endfunction

    function automatic int vl_width(input int vlmax);
        return $clog2(vlmax) + 1;
    endfunction
endpackage

// File: rtl/v_alu_lane.sv
// v_alu_lane: one element slice computing add/sub/mul modulo 2^SEW, zeroed outside the active length
module v_alu_lane
    import v_alu_pkg::*;
#(
    parameter int SEW       = 32,
    parameter int VALUOP_DW = 5
) (
    input  logic [VALUOP_DW-1:0] op_i,
    input  logic                 active_i,
    input  logic [SEW-1:0]       a_i,
    input  logic [SEW-1:0]       b_i,
    output logic [SEW-1:0]       res_o
);
    assign res_o = !active_i                    ? '0 :
                   op_i == VALUOP_DW'(OP_VADD)  ? a_i + b_i :
                   op_i == VALUOP_DW'(OP_VSUB)  ? a_i - b_i :
                   op_i == VALUOP_DW'(OP_VMUL)  ? a_i * b_i : '0;
endmodule

// File: rtl/v_alu_pipe.sv
// v_alu_pipe: pipelined vector ALU with valid/ready backpressure, vl tail mask and sum reduction
module v_alu_pipe
    import v_alu_pkg::*;
#(
    parameter int SEW         = 32,
    parameter int VLMAX       = 8,
    parameter int VALUOP_DW   = 5,
    parameter int VREG_DW     = 256,
    parameter int VREG_AW     = 5,
    parameter int PIPE_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [VALUOP_DW-1:0]       valu_opcode_i,
    input  logic [vl_width(VLMAX)-1:0] vl_i,
    input  logic [VREG_AW-1:0]         vd_addr_i,
    input  logic [VREG_DW-1:0]         operand_v1_i,
    input  logic [VREG_DW-1:0]         operand_v2_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [VREG_AW-1:0]         vd_addr_o,
    output logic [VREG_DW-1:0]         valu_result_o
);
    localparam int NL  = num_lanes(VREG_DW, SEW);
    localparam int NP  = (NL + 1) / 2;
    localparam int VLW = vl_width(VLMAX);
    localparam int PW  = VALUOP_DW + VREG_AW + VREG_DW + NP * SEW + SEW;

    logic [PIPE_STAGES-1:0] valid_q, valid_d, adv, up, load;
    // a stage advances when any stage from it downstream is empty or the consumer takes the head
    always_comb begin
        adv = '0;
        up = PIPE_STAGES'({valid_q, in_valid_i});
        for (int k = 0; k < PIPE_STAGES; k++) adv[k] = out_ready_i || ((~valid_q) >> k) != '0;
        load = adv & up;
        valid_d = load | (~adv & valid_q);
    end

    assign in_ready_o  = adv[0];
    assign out_valid_o = valid_q[PIPE_STAGES-1];

    logic [VALUOP_DW-1:0] op0_q;
    logic [VLW-1:0]       vl0_q;
    logic [VREG_AW-1:0]   tag0_q;
    logic [VREG_DW-1:0]   v1_q, v2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            op0_q   <= '0;
            vl0_q   <= '0;
            tag0_q  <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load[0]) begin
                op0_q  <= valu_opcode_i;
                vl0_q  <= vl_i;
                tag0_q <= vd_addr_i;
                v1_q   <= operand_v1_i;
                v2_q   <= operand_v2_i;
            end
        end
    end

    logic [NL-1:0]      act;
    logic [VREG_DW-1:0] lres, red;
    logic [NP*SEW-1:0]  part;

    genvar i;
    for (i = 0; i < NL; i++) begin : g_lane
        assign act[i] = VLW'(i) < vl0_q;
        assign red[i*SEW +: SEW] = act[i] ? v1_q[i*SEW +: SEW] : '0;
        v_alu_lane #(.SEW(SEW), .VALUOP_DW(VALUOP_DW)) u_lane (
            .op_i    (op0_q),
            .active_i(act[i]),
            .a_i     (v1_q[i*SEW +: SEW]),
            .b_i     (v2_q[i*SEW +: SEW]),
            .res_o   (lres[i*SEW +: SEW])
        );
    end

    // first level of the reduction tree: neighbouring elements summed pairwise
    always_comb begin
        part = '0;
        for (int j = 0; j < NL; j++) part[(j/2)*SEW +: SEW] = part[(j/2)*SEW +: SEW] + red[j*SEW +: SEW];
    end

    logic [PW-1:0]        comp0, fin;
    logic [VALUOP_DW-1:0] f_op;
    logic [VREG_AW-1:0]   f_tag;
    logic [VREG_DW-1:0]   f_lres;
    logic [NP*SEW-1:0]    f_part;
    logic [SEW-1:0]       f_acc, sum;

    assign comp0 = {op0_q, tag0_q, lres, part, v2_q[SEW-1:0]};

    if (PIPE_STAGES == 1) begin : g_comb
        assign fin = comp0;
    end else begin : g_regs
        logic [PIPE_STAGES-2:0][PW-1:0] cs_q;
        logic [PIPE_STAGES-1:0][PW-1:0] cs_src;
        assign cs_src = {cs_q, comp0};
        always_ff @(posedge clk) begin
            if (!rst) cs_q <= '0;
            else for (int k = 0; k < PIPE_STAGES - 1; k++) if (load[k+1]) cs_q[k] <= cs_src[k];
        end
        assign fin = cs_q[PIPE_STAGES-2];
    end

    assign {f_op, f_tag, f_lres, f_part, f_acc} = fin;
    assign vd_addr_o = f_tag;

    // remainder of the reduction tree runs after the final pipeline register
    always_comb begin
        sum = f_acc;
        for (int j = 0; j < NP; j++) sum = sum + f_part[j*SEW +: SEW];
        valu_result_o = f_op == VALUOP_DW'(OP_VREDSUM) ? VREG_DW'(sum) : f_lres;
    end
endmodule

// File: tb/tb_v_alu_pipe.sv
// tb_v_alu_pipe: randomized and directed scoreboard bench for the pipelined vector ALU
module tb_v_alu_pipe;
    localparam int P = 2;
    localparam longint unsigned M = 64'h1_0000_0000;

    typedef struct {
        logic [4:0]   tag;
        logic [255:0] res;
    } exp_t;

    logic         clk = 0, rst = 0, in_valid_i = 0, out_ready_i = 1;
    logic         in_ready_o, out_valid_o;
    logic [4:0]   valu_opcode_i = '0, vd_addr_i = '0, vd_addr_o;
    logic [3:0]   vl_i = '0;
    logic [255:0] operand_v1_i = '0, operand_v2_i = '0, valu_result_o;

    int   tests = 0, fails = 0, cyc = 0, acc_cnt = 0, last_acc = 0, first_block = -1, bp_base = 0;
    bit   bp_on = 0, rnd_done = 0;
    exp_t sb[$];

    v_alu_pipe #(.SEW(32), .VLMAX(8), .VALUOP_DW(5), .VREG_DW(256), .VREG_AW(5), .PIPE_STAGES(P)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .valu_opcode_i(valu_opcode_i), .vl_i(vl_i), .vd_addr_i(vd_addr_i),
        .operand_v1_i(operand_v1_i), .operand_v2_i(operand_v2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .vd_addr_o(vd_addr_o), .valu_result_o(valu_result_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model(input int op, input int vl, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r = '0;
        longint unsigned x, y, s;
        int n = vl > 8 ? 8 : vl;
        s = 64'(b[31:0]);
        for (int i = 0; i < n; i++) begin
            x = 64'(a[i*32 +: 32]);
            y = 64'(b[i*32 +: 32]);
            s = s + x;
            if (op == 1) r[i*32 +: 32] = 32'((x + y) % M);
            if (op == 3) r[i*32 +: 32] = 32'((x + M - y) % M);
            if (op == 2) r[i*32 +: 32] = 32'((x * y) % M);
        end
        if (op == 4) r = {224'd0, 32'(s % M)};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input int vl, input logic [4:0] tag, input logic [255:0] a, input logic [255:0] b);
        int waits = 0;
        bit ok = 0;
        valu_opcode_i = 5'(op);
        vl_i = 4'(vl);
        vd_addr_i = tag;
        operand_v1_i = a;
        operand_v2_i = b;
        in_valid_i = 1;
        while (!ok && waits < 200) begin
            @(negedge clk);
            if (in_ready_o) ok = 1;
            else begin
                if (bp_on && first_block < 0) first_block = acc_cnt - bp_base;
                waits++;
            end
        end
        if (ok) begin
            sb.push_back('{tag, model(op, vl, a, b)});
            acc_cnt++;
            last_acc = cyc;
        end else chk("accept_timeout", 256'(0), 256'(1));
        step();
        in_valid_i = 0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            step();
            w++;
        end
        chk("drain_left", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        logic         held = 0;
        logic [4:0]   htag = '0;
        logic [255:0] hres = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst) held = 0;
            else begin
                if (held) begin
                    chk("stall_valid", 256'(out_valid_o), 256'(1));
                    chk("stall_tag", 256'(vd_addr_o), 256'(htag));
                    chk("stall_res", valu_result_o, hres);
                end
                held = out_valid_o && !out_ready_i;
                htag = vd_addr_o;
                hres = valu_result_o;
                if (out_valid_o && out_ready_i) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out: got beat tag %0d, required no beat", vd_addr_o);
                    end else begin
                        e = sb.pop_front();
                        chk("out_tag", 256'(vd_addr_o), 256'(e.tag));
                        chk("out_res", valu_result_o, e.res);
                    end
                end
            end
        end
    end

    initial begin
        logic [255:0] a, b;
        int w;
        repeat (3) step();
        chk("rst_valid", 256'(out_valid_o), 256'(0));
        chk("rst_res", valu_result_o, 256'(0));
        chk("rst_tag", 256'(vd_addr_o), 256'(0));
        rst = 1;
        @(negedge clk);
        chk("rst_ready", 256'(in_ready_o), 256'(1));
        step();

        for (int i = 0; i < 8; i++) begin
            a[i*32 +: 32] = 32'(i);
            b[i*32 +: 32] = 32'd10;
        end
        send(1, 8, 5'd5, a, b);
        w = 0;
        @(negedge clk);
        while (!out_valid_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("latency", 256'(cyc - last_acc), 256'(P));
        chk("vadd_elem7", valu_result_o[255:224], 256'(17));
        chk("vadd_tag", 256'(vd_addr_o), 256'(5));
        step();

        for (int i = 0; i < 8; i++) begin
            a[i*32 +: 32] = 32'h10000;
            b[i*32 +: 32] = 32'h10000;
        end
        send(2, 8, 5'd6, a, b);
        send(3, 8, 5'd7, 256'd0, {8{32'd1}});
        send(1, 3, 5'd8, {8{$urandom}}, {8{$urandom}});
        for (int i = 0; i < 8; i++) begin
            a[i*32 +: 32] = 32'(i + 1);
            b[i*32 +: 32] = $urandom;
        end
        b[31:0] = 32'd100;
        send(4, 8, 5'd9, a, b);
        send(4, 0, 5'd10, a, b);
        send(4, 13, 5'd11, a, b);
        send(0, 8, 5'd12, a, b);
        send(7, 8, 5'd13, a, b);
        send(2, 12, 5'd14, {8{$urandom}}, {8{$urandom}});
        drain();

        out_ready_i = 0;
        bp_on = 1;
        bp_base = acc_cnt;
        fork
            for (int k = 0; k < 6; k++) send(1, 8, 5'(16 + k), {8{$urandom}}, {8{$urandom}});
            begin
                repeat (5) step();
                out_ready_i = 1;
            end
        join
        bp_on = 0;
        chk("bp_ready_drop", 256'(first_block), 256'(P));
        drain();

        fork
            begin
                for (int k = 0; k < 150; k++)
                    send($urandom_range(0, 7), $urandom_range(0, 15), 5'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
                rnd_done = 1;
            end
            while (!rnd_done) begin
                step();
                out_ready_i = !out_ready_i;
            end
        join
        out_ready_i = 1;
        drain();

        out_ready_i = 0;
        send(1, 8, 5'd1, {8{$urandom}}, {8{$urandom}});
        send(3, 8, 5'd2, {8{$urandom}}, {8{$urandom}});
        rst = 0;
        step();
        rst = 1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", 256'(out_valid_o), 256'(0));
        chk("mid_rst_ready", 256'(in_ready_o), 256'(1));
        chk("mid_rst_res", valu_result_o, 256'(0));
        out_ready_i = 1;
        repeat (10) step();
        send(1, 2, 5'd30, {8{32'd3}}, {8{32'd4}});
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/v_alu_pipe.md
Name: v_alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle vector ALU in the vector execute path.
- Processes NUM_LANES = VREG_DW/SEW elements per beat through a fixed PIPE_STAGES-deep pipeline.
- Uses a valid/ready handshake on input and output, with full backpressure.
- Adds VSUB, a vector-length (vl) tail mask and a sum-reduction op to the existing NOP/VADD/VMUL set.

Parameters:
- SEW, 32: element width in bits; legal values 8, 16, 32.
- VLMAX, 8: maximum elements per register; VLMAX*SEW must equal VREG_DW.
- VALUOP_DW, 5: opcode width.
- VREG_DW, 256: vector register width.
- VREG_AW, 5: destination register address width (carried as tag).
- PIPE_STAGES, 2: pipeline depth, 1..4; sets latency.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat this cycle.
- valu_opcode_i  in  VALUOP_DW  operation.
- vl_i  in  $clog2(VLMAX)+1  active element count, 0..VLMAX.
- vd_addr_i  in  VREG_AW  destination tag, passed through unchanged.
- operand_v1_i  in  VREG_DW  source vector 1; element i = bits [i*SEW +: SEW].
- operand_v2_i  in  VREG_DW  source vector 2.
- out_valid_o  out  1  result beat valid.
- out_ready_i  in  1  consumer accepts result.
- vd_addr_o  out  VREG_AW  tag of the result.
- valu_result_o  out  VREG_DW  result vector.

Behaviour:
- Opcodes: NOP=0, VADD=1, VMUL=2, VSUB=3, VREDSUM=4. Any other code behaves as NOP.
- Per-element arithmetic, all modulo 2^SEW, no saturation, no flags:
  - VADD: v1[i]+v2[i].
  - VSUB: v1[i]-v2[i].
  - VMUL: low SEW bits of v1[i]*v2[i].
- VREDSUM: element 0 = v2[0] + sum of v1[i] for i<vl, modulo 2^SEW. Elements 1..VLMAX-1 are zero.
- NOP: result is all zero. The beat still flows through the pipeline and produces an out_valid beat.
- Tail mask: elements i >= vl_i are forced to zero for VADD/VSUB/VMUL.
  - vl_i=0 gives an all-zero result, except VREDSUM, which gives v2[0] in element 0.
  - vl_i > VLMAX is clamped to VLMAX.
- Latency: a beat accepted in cycle t appears on out_valid_o in cycle t+PIPE_STAGES, provided no stall occurs.
- Throughput: one beat per cycle with no bubbles.
- Pipeline storage: each stage holds a valid bit plus its payload (opcode, vl, tag, operands or partial results).
- Stage advance: stage k advances when it is empty or the stage downstream of it advances. The last stage advances on out_ready_i.
- Ready rule: in_ready_o = !valid[0] || advance[0]. It is combinational from out_ready_i; no skid buffer is required.
- Transfer: an input transfer occurs when in_valid_i && in_ready_o. An output transfer occurs when out_valid_o && out_ready_i.
- Stall: with out_valid_o=1 and out_ready_i=0, all outputs hold stable until a transfer.
- Simultaneous input and output transfer in one cycle is legal; occupancy stays unchanged.
- Computation split: when PIPE_STAGES >= 2, the multiply and the reduction adder tree are split across stages. The split point is implementation choice, but latency must equal PIPE_STAGES exactly for every opcode.
- Reset (rst=0 at a clock edge):
  - All stage valid bits clear; out_valid_o=0; valu_result_o=0; vd_addr_o=0.
  - in_ready_o=1 from the first cycle after reset releases.
  - Beats in flight when reset asserts are discarded and never emitted.
- Beats leave in order; there is no reordering and no dropping.

Decomposition:
- Shared package v_alu_pkg holds:
  - the opcode localparams (NOP/VADD/VMUL/VSUB/VREDSUM);
  - a NUM_LANES derivation;
  - the vl width function.
- Sub-module v_alu_lane: one SEW-wide add/sub/mul element slice with tail-mask input. It is instantiated NUM_LANES times via generate.
- The reduction tree and the pipeline valid/advance control stay in the top module.

Test Plan:
- Basic VADD, SEW=32, vl=8, out_ready_i held 1:
  - Stimulus: v1[i]=i, v2[i]=10.
  - Required: result[i]=10+i, out_valid_o exactly 2 cycles after acceptance, vd_addr_o equal to the input tag.
- Modulo wrap and masking:
  - VMUL with v1[i]=0x10000, v2[i]=0x10000 → all elements 0.
  - VSUB with v1[i]=0, v2[i]=1 → all elements 0xFFFFFFFF.
  - VADD with vl=3 → elements 3..7 are 0.
- VREDSUM, vl=8:
  - Stimulus: v1[i]=i+1, v2[0]=100.
  - Required: element 0 = 136, others 0.
  - Repeat with vl=0 → element 0 = 100.
- Backpressure:
  - Stimulus: stream 6 back-to-back VADD beats while out_ready_i=0 for 5 cycles.
  - Required: in_ready_o drops after PIPE_STAGES beats; output held stable while stalled; all 6 beats emerge in order with no loss or duplication.
- Full throughput:
  - Stimulus: continuous in_valid_i with out_ready_i toggling 1/0 each cycle.
  - Required: every accepted beat is emitted exactly once, and tags match a scoreboard.
- Reset mid-stream:
  - Stimulus: pulse rst=0 for 1 cycle while 2 beats are in flight.
  - Required: out_valid_o=0 the next cycle, no stale beats ever appear, in_ready_o=1 after release.
